// File: rtl/arith_seq_pkg.sv
// Shared definitions for the arithmetic-port sequencer: FSM encoding,
// register offsets, CTRL/STATUS bit positions and the block ID word.
package arith_seq_pkg;

   // Sequencer states, one per RAM/adder phase of a pair
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_A     = 3'd1,
      ST_RD_B     = 3'd2,
      ST_CAP_B    = 3'd3,
      ST_ISSUE    = 3'd4,
      ST_WAIT_RES = 3'd5,
      ST_WRITE    = 3'd6
   } state_e;

   // Avalon register offsets
   localparam logic [2:0] REG_SRC_A  = 3'd0;
   localparam logic [2:0] REG_SRC_B  = 3'd1;
   localparam logic [2:0] REG_DST    = 3'd2;
   localparam logic [2:0] REG_LEN    = 3'd3;
   localparam logic [2:0] REG_CTRL   = 3'd4;
   localparam logic [2:0] REG_STATUS = 3'd5;
   localparam logic [2:0] REG_COUNT  = 3'd6;
   localparam logic [2:0] REG_ID     = 3'd7;

   // CTRL bit positions
   localparam int CTRL_START_BIT = 0;
   localparam int CTRL_ABORT_BIT = 1;
   localparam int CTRL_CLEAR_BIT = 2;

   // STATUS bit positions
   localparam int STAT_BUSY_BIT    = 0;
   localparam int STAT_DONE_BIT    = 1;
   localparam int STAT_ABORTED_BIT = 2;

   // Identification word ("ASC1")
   localparam logic [31:0] ID_VALUE = 32'h4153_4331;

   // Assemble the STATUS read word from the three flags
   function automatic logic [31:0] status_word(input logic busy,
                                               input logic done,
                                               input logic aborted);
      logic [31:0] w;
      w = '0;
      w[STAT_BUSY_BIT]    = busy;
      w[STAT_DONE_BIT]    = done;
      w[STAT_ABORTED_BIT] = aborted;
      return w;
   endfunction

endpackage

// File: rtl/arith_seq_regs.sv
// Avalon-MM register file for the sequencer. Holds the programmed
// configuration, decodes CTRL writes into single-cycle pulses and
// produces registered read data with one cycle of latency.
module arith_seq_regs
   import arith_seq_pkg::*;
#(
   parameter int ADDR_WIDTH = 11
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  read_i,
   input  logic                  write_i,
   input  logic [2:0]            address_i,
   input  logic [31:0]           writedata_i,
   output logic [31:0]           readdata_o,
   input  logic                  busy_i,
   input  logic                  done_i,
   input  logic                  aborted_i,
   input  logic [ADDR_WIDTH:0]   count_i,
   output logic [ADDR_WIDTH-1:0] src_a_o,
   output logic [ADDR_WIDTH-1:0] src_b_o,
   output logic [ADDR_WIDTH-1:0] dst_o,
   output logic [ADDR_WIDTH:0]   len_o,
   output logic                  start_o,
   output logic                  abort_o,
   output logic                  clear_o
);

   logic [ADDR_WIDTH-1:0] src_a_q;
   logic [ADDR_WIDTH-1:0] src_b_q;
   logic [ADDR_WIDTH-1:0] dst_q;
   logic [ADDR_WIDTH:0]   len_q;
   logic [31:0]           readdata_q;
   logic [31:0]           readdata_d;
   logic                  ctrl_wr;
   logic                  unused_wdata;

   // Bits above the LEN field are never stored anywhere
   assign unused_wdata = ^writedata_i[31:ADDR_WIDTH+1];

   // CTRL writes are acted on in the same cycle by the FSM
   assign ctrl_wr = write_i && (address_i == REG_CTRL);
   assign start_o = ctrl_wr && writedata_i[CTRL_START_BIT];
   assign abort_o = ctrl_wr && writedata_i[CTRL_ABORT_BIT];
   assign clear_o = ctrl_wr && writedata_i[CTRL_CLEAR_BIT];

   // Read mux; offset 4 and anything unmapped return zero
   always_comb begin
      readdata_d = '0;
      case (address_i)
         REG_SRC_A:  readdata_d = 32'(src_a_q);
         REG_SRC_B:  readdata_d = 32'(src_b_q);
         REG_DST:    readdata_d = 32'(dst_q);
         REG_LEN:    readdata_d = 32'(len_q);
         REG_STATUS: readdata_d = status_word(busy_i, done_i, aborted_i);
         REG_COUNT:  readdata_d = 32'(count_i);
         REG_ID:     readdata_d = ID_VALUE;
         default:    readdata_d = '0;
      endcase
   end

   // Config writes (locked while a run is in progress) and read data capture
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         src_a_q    <= '0;
         src_b_q    <= '0;
         dst_q      <= '0;
         len_q      <= '0;
         readdata_q <= '0;
      end else begin
         if (write_i && !busy_i) begin
            case (address_i)
               REG_SRC_A: src_a_q <= writedata_i[ADDR_WIDTH-1:0];
               REG_SRC_B: src_b_q <= writedata_i[ADDR_WIDTH-1:0];
               REG_DST:   dst_q   <= writedata_i[ADDR_WIDTH-1:0];
               REG_LEN:   len_q   <= writedata_i[ADDR_WIDTH:0];
               default: ;
            endcase
         end
         if (read_i) begin
            readdata_q <= readdata_d;
         end
      end
   end

   assign readdata_o = readdata_q;
   assign src_a_o    = src_a_q;
   assign src_b_o    = src_b_q;
   assign dst_o      = dst_q;
   assign len_o      = len_q;

endmodule

// File: rtl/arith_seq_ctrl.sv
// Arithmetic-port sequencer: walks LEN operand pairs out of RAM port B,
// hands each pair to the adder over valid/ready, and writes the sum back
// to the destination region. Config and status live in arith_seq_regs.
module arith_seq_ctrl
   import arith_seq_pkg::*;
#(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  read,
   input  logic                  write,
   input  logic [2:0]            address,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [ADDR_WIDTH-1:0] addr_arith,
   output logic                  we_arith,
   output logic [DATA_WIDTH-1:0] data_arith,
   input  logic [DATA_WIDTH-1:0] q_arith,
   output logic [DATA_WIDTH-1:0] op_a,
   output logic [DATA_WIDTH-1:0] op_b,
   output logic                  op_valid,
   input  logic                  op_ready,
   input  logic [DATA_WIDTH-1:0] res_data,
   input  logic                  res_valid,
   output logic                  done_irq
);

   state_e                state_q;
   logic [ADDR_WIDTH:0]   i_q;
   logic [ADDR_WIDTH:0]   i_inc;
   logic [ADDR_WIDTH:0]   count_q;
   logic [ADDR_WIDTH-1:0] base_a_q;
   logic [ADDR_WIDTH-1:0] base_b_q;
   logic [ADDR_WIDTH-1:0] base_d_q;
   logic [ADDR_WIDTH:0]   len_q;
   logic [DATA_WIDTH-1:0] op_a_q;
   logic [DATA_WIDTH-1:0] op_b_q;
   logic [DATA_WIDTH-1:0] res_q;
   logic                  op_valid_q;
   logic                  done_q;
   logic                  aborted_q;
   logic [ADDR_WIDTH-1:0] addr_last_q;
   logic [ADDR_WIDTH-1:0] addr_d;
   logic                  busy;

   logic [ADDR_WIDTH-1:0] cfg_src_a;
   logic [ADDR_WIDTH-1:0] cfg_src_b;
   logic [ADDR_WIDTH-1:0] cfg_dst;
   logic [ADDR_WIDTH:0]   cfg_len;
   logic                  start_p;
   logic                  abort_p;
   logic                  clear_p;

   assign busy  = (state_q != ST_IDLE);
   assign i_inc = i_q + (ADDR_WIDTH+1)'(1);

   arith_seq_regs #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_regs (
      .clk_i       (clock),
      .rst_ni      (resetn),
      .read_i      (read),
      .write_i     (write),
      .address_i   (address),
      .writedata_i (writedata),
      .readdata_o  (readdata),
      .busy_i      (busy),
      .done_i      (done_q),
      .aborted_i   (aborted_q),
      .count_i     (count_q),
      .src_a_o     (cfg_src_a),
      .src_b_o     (cfg_src_b),
      .dst_o       (cfg_dst),
      .len_o       (cfg_len),
      .start_o     (start_p),
      .abort_o     (abort_p),
      .clear_o     (clear_p)
   );

   // Port B address: element addresses wrap within the RAM; otherwise hold
   always_comb begin
      addr_d = addr_last_q;
      case (state_q)
         ST_RD_A:  addr_d = base_a_q + i_q[ADDR_WIDTH-1:0];
         ST_RD_B:  addr_d = base_b_q + i_q[ADDR_WIDTH-1:0];
         ST_WRITE: addr_d = base_d_q + i_q[ADDR_WIDTH-1:0];
         default:  addr_d = addr_last_q;
      endcase
   end

   assign addr_arith = addr_d;
   assign we_arith   = (state_q == ST_WRITE);
   assign data_arith = res_q;
   assign op_a       = op_a_q;
   assign op_b       = op_b_q;
   assign op_valid   = op_valid_q;
   assign done_irq   = done_q;

   // Sequencer FSM with its counters, operand/result latches and flags
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         i_q         <= '0;
         count_q     <= '0;
         base_a_q    <= '0;
         base_b_q    <= '0;
         base_d_q    <= '0;
         len_q       <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         res_q       <= '0;
         op_valid_q  <= 1'b0;
         done_q      <= 1'b0;
         aborted_q   <= 1'b0;
         addr_last_q <= '0;
      end else begin
         addr_last_q <= addr_d;
         if (clear_p) begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
         end
         if (abort_p && busy) begin
            // Abort leaves done and COUNT untouched
            state_q    <= ST_IDLE;
            op_valid_q <= 1'b0;
            aborted_q  <= 1'b1;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start_p && !abort_p) begin
                     done_q    <= (cfg_len == '0);
                     aborted_q <= 1'b0;
                     count_q   <= '0;
                     i_q       <= '0;
                     base_a_q  <= cfg_src_a;
                     base_b_q  <= cfg_src_b;
                     base_d_q  <= cfg_dst;
                     len_q     <= cfg_len;
                     if (cfg_len != '0) begin
                        state_q <= ST_RD_A;
                     end
                  end
               end
               ST_RD_A: begin
                  state_q <= ST_RD_B;
               end
               ST_RD_B: begin
                  // q_arith carries A[i] from the address presented in RD_A
                  op_a_q  <= q_arith;
                  state_q <= ST_CAP_B;
               end
               ST_CAP_B: begin
                  op_b_q     <= q_arith;
                  op_valid_q <= 1'b1;
                  state_q    <= ST_ISSUE;
               end
               ST_ISSUE: begin
                  if (op_ready) begin
                     op_valid_q <= 1'b0;
                     state_q    <= ST_WAIT_RES;
                  end
               end
               ST_WAIT_RES: begin
                  if (res_valid) begin
                     res_q   <= res_data;
                     state_q <= ST_WRITE;
                  end
               end
               ST_WRITE: begin
                  i_q     <= i_inc;
                  count_q <= count_q + (ADDR_WIDTH+1)'(1);
                  if (i_inc == len_q) begin
                     done_q  <= 1'b1;
                     state_q <= ST_IDLE;
                  end else begin
                     state_q <= ST_RD_A;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_arith_seq_ctrl.sv
// Bench for arith_seq_ctrl: behavioural 1-cycle RAM, a 3-cycle adder
// with optional back-pressure, and a write scoreboard.
module tb_arith_seq_ctrl;
   import arith_seq_pkg::*;

   localparam int AW = 11;
   localparam int DW = 32;

   logic          clock = 1'b0;
   logic          resetn;
   logic          read;
   logic          write;
   logic [2:0]    address;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic [AW-1:0] addr_arith;
   logic          we_arith;
   logic [DW-1:0] data_arith;
   logic [DW-1:0] q_arith;
   logic [DW-1:0] op_a;
   logic [DW-1:0] op_b;
   logic          op_valid;
   logic          op_ready;
   logic [DW-1:0] res_data;
   logic          res_valid;
   logic          done_irq;

   always #5 clock = ~clock;

   arith_seq_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .read       (read),
      .write      (write),
      .address    (address),
      .writedata  (writedata),
      .readdata   (readdata),
      .addr_arith (addr_arith),
      .we_arith   (we_arith),
      .data_arith (data_arith),
      .q_arith    (q_arith),
      .op_a       (op_a),
      .op_b       (op_b),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .res_data   (res_data),
      .res_valid  (res_valid),
      .done_irq   (done_irq)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Behavioural RAM with a backdoor load port
   logic [31:0]   mem [0:2047];
   logic          bd_we = 1'b0;
   logic [AW-1:0] bd_addr = '0;
   logic [31:0]   bd_data = '0;

   always @(posedge clock) begin
      if (bd_we) mem[bd_addr] <= bd_data;
      else if (we_arith) mem[addr_arith] <= data_arith;
      q_arith <= mem[addr_arith];
   end

   // Adder: a+b returned three cycles after acceptance
   logic [2:0]  pv = '0;
   logic [31:0] pd0, pd1, pd2;
   always @(posedge clock) begin
      pv  <= {pv[1:0], op_valid && op_ready};
      pd0 <= op_a + op_b;
      pd1 <= pd0;
      pd2 <= pd1;
   end
   assign res_valid = pv[2];
   assign res_data  = pd2;

   // Ready generator: with bp_mode, ready stays low 5 cycles per pair
   logic bp_mode = 1'b0;
   logic rdy = 1'b1;
   int   bp_cnt = 0;
   always @(posedge clock) begin
      if (!bp_mode) begin
         rdy    <= 1'b1;
         bp_cnt <= 0;
      end else if (op_valid && !rdy) begin
         bp_cnt <= bp_cnt + 1;
         if (bp_cnt == 4) rdy <= 1'b1;
      end else begin
         rdy    <= 1'b0;
         bp_cnt <= 0;
      end
   end
   assign op_ready = rdy;

   // Scoreboard of expected port B writes and operand stability monitor
   typedef struct packed {
      logic [AW-1:0] a;
      logic [31:0]   d;
   } wr_t;
   wr_t         exp_q[$];
   int          wr_count = 0;
   logic        pend = 1'b0;
   logic [31:0] ha = '0;
   logic [31:0] hb = '0;

   always @(negedge clock) begin
      if (resetn === 1'b1 && we_arith === 1'b1) begin
         wr_count <= wr_count + 1;
         if (exp_q.size() == 0) begin
            chk("wr_unexpected_addr", 32'(addr_arith), 32'hFFFF_FFFF);
         end else begin
            chk("wr_addr", 32'(addr_arith), 32'(exp_q[0].a));
            chk("wr_data", data_arith, exp_q[0].d);
            void'(exp_q.pop_front());
         end
      end
      if (pend) begin
         chk("op_valid_held", 32'(op_valid), 32'd1);
         chk("op_a_stable", op_a, ha);
         chk("op_b_stable", op_b, hb);
      end
      pend <= op_valid && !op_ready;
      ha   <= op_a;
      hb   <= op_b;
   end

   logic [31:0] va [0:7];
   logic [31:0] vb [0:7];

   task automatic av_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clock);
      address = a; writedata = d; write = 1'b1;
      @(negedge clock);
      write = 1'b0;
   endtask

   task automatic av_read(input logic [2:0] a, output logic [31:0] d);
      @(negedge clock);
      address = a; read = 1'b1;
      @(negedge clock);
      read = 1'b0;
      d = readdata;
   endtask

   task automatic ram_load(input logic [AW-1:0] a, input logic [31:0] d);
      @(negedge clock);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      @(negedge clock);
      bd_we = 1'b0;
   endtask

   task automatic setup_run(input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                            input logic [AW-1:0] ds, input int len);
      for (int k = 0; k < len; k++) begin
         ram_load(sa + AW'(k), va[k]);
         ram_load(sb + AW'(k), vb[k]);
         exp_q.push_back('{a: ds + AW'(k), d: va[k] + vb[k]});
      end
      av_write(REG_SRC_A, 32'(sa));
      av_write(REG_SRC_B, 32'(sb));
      av_write(REG_DST, 32'(ds));
      av_write(REG_LEN, 32'(len));
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (done_irq !== 1'b1 && n < budget) begin
         @(negedge clock);
         n++;
      end
      chk(tag, 32'(done_irq), 32'd1);
   endtask

   logic [31:0] rd;
   int          w0;

   initial begin
      resetn = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
      repeat (3) @(negedge clock);
      chk("rst_readdata", readdata, 32'd0);
      chk("rst_addr", 32'(addr_arith), 32'd0);
      chk("rst_we", 32'(we_arith), 32'd0);
      chk("rst_data", data_arith, 32'd0);
      chk("rst_op_valid", 32'(op_valid), 32'd0);
      chk("rst_op_a", op_a, 32'd0);
      chk("rst_op_b", op_b, 32'd0);
      chk("rst_done_irq", 32'(done_irq), 32'd0);
      resetn = 1'b1;
      @(negedge clock);
      av_read(REG_ID, rd);     chk("id", rd, 32'h4153_4331);
      av_read(REG_STATUS, rd); chk("rst_status", rd, 32'd0);
      av_read(REG_COUNT, rd);  chk("rst_count", rd, 32'd0);

      // Basic run, with a restart and LEN write attempted while busy
      va[0] = 1;  va[1] = 2;  va[2] = 3;  va[3] = 4;
      vb[0] = 10; vb[1] = 20; vb[2] = 30; vb[3] = 40;
      setup_run(11'd0, 11'd16, 11'd32, 4);
      av_write(REG_CTRL, 32'h1);
      av_write(REG_CTRL, 32'h1);
      av_write(REG_LEN, 32'd1);
      wait_done("basic_done", 300);
      chk("basic_ram32", mem[32], 32'd11);
      chk("basic_ram33", mem[33], 32'd22);
      chk("basic_ram34", mem[34], 32'd33);
      chk("basic_ram35", mem[35], 32'd44);
      av_read(REG_COUNT, rd);  chk("basic_count", rd, 32'd4);
      av_read(REG_STATUS, rd); chk("basic_status", rd, 32'h2);
      av_read(REG_LEN, rd);    chk("busy_len_kept", rd, 32'd4);
      chk("basic_irq", 32'(done_irq), 32'd1);
      chk("basic_queue_left", 32'(exp_q.size()), 32'd0);

      // Back-pressure with source A wrapping past the top of RAM
      bp_mode = 1'b1;
      va[0] = 5;   va[1] = 6;   va[2] = 7;
      vb[0] = 100; vb[1] = 200; vb[2] = 300;
      setup_run(11'd2046, 11'd100, 11'd200, 3);
      w0 = wr_count;
      av_write(REG_CTRL, 32'h1);
      wait_done("bp_done", 400);
      chk("bp_write_count", 32'(wr_count - w0), 32'd3);
      chk("bp_queue_left", 32'(exp_q.size()), 32'd0);
      bp_mode = 1'b0;

      // Abort after the second write
      for (int k = 0; k < 8; k++) begin
         va[k] = 32'(1000 + k);
         vb[k] = 32'(2000 + 3 * k);
      end
      setup_run(11'd300, 11'd400, 11'd500, 8);
      w0 = wr_count;
      av_write(REG_CTRL, 32'h1);
      begin
         int n = 0;
         while ((wr_count - w0) < 2 && n < 200) begin
            @(negedge clock);
            n++;
         end
      end
      chk("abort_reached_2", 32'(wr_count - w0), 32'd2);
      av_write(REG_CTRL, 32'h2);
      repeat (40) @(negedge clock);
      chk("abort_writes", 32'(wr_count - w0), 32'd2);
      av_read(REG_STATUS, rd); chk("abort_status", rd, 32'h4);
      av_read(REG_COUNT, rd);  chk("abort_count", rd, 32'd2);
      chk("abort_irq", 32'(done_irq), 32'd0);
      chk("abort_queue_left", 32'(exp_q.size()), 32'd6);
      exp_q.delete();
      av_write(REG_CTRL, 32'h4);
      av_read(REG_STATUS, rd); chk("clear_status", rd, 32'd0);

      // LEN=0: done without touching RAM
      av_write(REG_LEN, 32'd0);
      w0 = wr_count;
      av_write(REG_CTRL, 32'h1);
      chk("len0_irq", 32'(done_irq), 32'd1);
      av_read(REG_STATUS, rd); chk("len0_status", rd, 32'h2);
      chk("len0_no_write", 32'(wr_count - w0), 32'd0);

      // Reset asserted during the first WRITE
      for (int k = 0; k < 4; k++) begin
         va[k] = 32'(50 + k);
         vb[k] = 32'(60 + k);
      end
      setup_run(11'd600, 11'd700, 11'd800, 4);
      av_write(REG_CTRL, 32'h1);
      begin
         int n = 0;
         while (we_arith !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
         end
      end
      chk("rstmid_in_write", 32'(we_arith), 32'd1);
      #2 resetn = 1'b0;
      #1;
      chk("rstmid_addr", 32'(addr_arith), 32'd0);
      chk("rstmid_we", 32'(we_arith), 32'd0);
      chk("rstmid_data", data_arith, 32'd0);
      chk("rstmid_op_valid", 32'(op_valid), 32'd0);
      chk("rstmid_op_a", op_a, 32'd0);
      chk("rstmid_op_b", op_b, 32'd0);
      chk("rstmid_irq", 32'(done_irq), 32'd0);
      chk("rstmid_readdata", readdata, 32'd0);
      w0 = wr_count;
      @(negedge clock);
      resetn = 1'b1;
      repeat (20) @(negedge clock);
      chk("rstmid_no_more_writes", 32'(wr_count - w0), 32'd0);
      exp_q.delete();
      av_read(REG_STATUS, rd); chk("rstmid_status", rd, 32'd0);
      av_read(REG_COUNT, rd);  chk("rstmid_count", rd, 32'd0);
      av_read(REG_SRC_A, rd);  chk("rstmid_src_a", rd, 32'd0);
      av_read(REG_LEN, rd);    chk("rstmid_len", rd, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
